// File: rtl/mm2s_burst_reader.sv
// AXI4 read master: splits a start command into 4KB-safe INCR bursts, streams data out.
// Optional stall counter enabled by defining MM2S_PERF_CNT_EN.
module mm2s_burst_reader #(
    parameter int         ADDR_W    = 32,
    parameter int         DATA_W    = 128,
    parameter int         CNT_W     = 24,
    parameter int         MAX_BURST = 16,
    parameter logic [3:0] AR_CACHE  = 4'b0011,
    parameter logic [2:0] AR_PROT   = 3'b000,
    parameter logic [4:0] AR_USER   = 5'b00000
) (
    input  logic              clk_100_clk,
    input  logic              reset_reset_n,
    input  logic              ctrl_start,
    input  logic              ctrl_abort,
    input  logic [ADDR_W-1:0] cfg_base_addr,
    input  logic [CNT_W-1:0]  cfg_num_beats,
    output logic              status_busy,
    output logic              status_done,
    output logic              status_err,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [7:0]        m_arlen,
    output logic [2:0]        m_arsize,
    output logic [1:0]        m_arburst,
    output logic [3:0]        m_arcache,
    output logic [2:0]        m_arprot,
    output logic [4:0]        m_aruser,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rlast,
    input  logic              m_rvalid,
    output logic              m_rready,
    output logic [DATA_W-1:0] st_data,
    output logic              st_last,
    output logic              st_valid,
    input  logic              st_ready,
    output logic [31:0]       perf_stall_cnt
);

    localparam int BPB = DATA_W / 8;
    localparam int LB  = $clog2(BPB);
    localparam int CW  = (CNT_W > 14) ? CNT_W : 14;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    logic [1:0]        r_state;
    logic              r_sq1;
    logic              r_sq2;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic              r_abort;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_rem;
    logic              r_arvalid;
    logic [ADDR_W-1:0] r_araddr;
    logic [7:0]        r_arlen;
    logic              r_v0;
    logic              r_v1;
    logic [DATA_W-1:0] r_d0;
    logic [DATA_W-1:0] r_d1;
    logic              r_l0;
    logic              r_l1;

    logic              w_start;
    logic              w_abort;
    logic              w_flush;
    logic              w_rhs;
    logic              w_push;
    logic              w_pop;
    logic              w_last_in;
    logic [CW-1:0]     w_page;
    logic [CW-1:0]     w_rem;
    logic [CW-1:0]     w_beats;

    assign w_start   = r_sq1 && !r_sq2 && (r_state == S_IDLE);
    assign w_abort   = ctrl_abort || r_abort;
    assign w_flush   = w_abort && (r_state != S_IDLE);
    assign m_rready  = (r_state == S_DATA) && (w_abort || !r_v1);
    assign w_rhs     = m_rvalid && m_rready;
    assign w_push    = w_rhs && !w_abort;
    assign w_pop     = r_v0 && st_ready;
    // Remaining count already excludes the burst in flight, so zero marks the final burst.
    assign w_last_in = m_rlast && (r_rem == '0);

    assign w_page = CW'((13'd4096 - {1'b0, r_addr[11:0]}) >> LB);
    assign w_rem  = CW'(r_rem);

    always_comb begin
        w_beats = CW'(MAX_BURST);
        if (w_page < w_beats) w_beats = w_page;
        if (w_rem < w_beats) w_beats = w_rem;
    end

    always_ff @(posedge clk_100_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_sq1 <= 1'b0;
            r_sq2 <= 1'b0;
        end else begin
            r_sq1 <= ctrl_start;
            r_sq2 <= r_sq1;
        end
    end

    always_ff @(posedge clk_100_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_abort   <= 1'b0;
            r_addr    <= '0;
            r_rem     <= '0;
            r_arvalid <= 1'b0;
            r_araddr  <= '0;
            r_arlen   <= '0;
        end else begin
            if ((r_state != S_IDLE) && ctrl_abort) r_abort <= 1'b1;
            if (w_rhs && (m_rresp != 2'b00)) r_err <= 1'b1;
            unique case (r_state)
                S_IDLE: begin
                    r_abort <= 1'b0;
                    if (w_start) begin
                        r_addr  <= cfg_base_addr & ~ADDR_W'(BPB - 1);
                        r_rem   <= cfg_num_beats;
                        r_done  <= 1'b0;
                        r_err   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= (cfg_num_beats == '0) ? S_FIN : S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (!r_arvalid) begin
                        if (w_abort) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_abort <= 1'b0;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_araddr  <= r_addr;
                            r_arlen   <= 8'(w_beats - CW'(1));
                        end
                    end else if (m_arready) begin
                        r_arvalid <= 1'b0;
                        r_addr    <= r_addr + ((ADDR_W'(r_arlen) + ADDR_W'(1)) << LB);
                        r_rem     <= r_rem - (CNT_W'(r_arlen) + CNT_W'(1));
                        r_state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_rhs && m_rlast) begin
                        if (w_abort) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_abort <= 1'b0;
                        end else if (r_rem != '0) begin
                            r_state <= S_ADDR;
                        end else begin
                            r_state <= S_FIN;
                        end
                    end
                end
                S_FIN: begin
                    if (w_abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_abort <= 1'b0;
                    end else if (!r_v0 && !r_v1) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Two-entry skid: r_*0 is the registered stream head, r_*1 absorbs one stalled beat.
    always_ff @(posedge clk_100_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_v0 <= 1'b0;
            r_v1 <= 1'b0;
            r_d0 <= '0;
            r_d1 <= '0;
            r_l0 <= 1'b0;
            r_l1 <= 1'b0;
        end else if (w_flush) begin
            r_v0 <= 1'b0;
            r_v1 <= 1'b0;
            r_l0 <= 1'b0;
        end else if (r_v1) begin
            if (w_pop) begin
                r_d0 <= r_d1;
                r_l0 <= r_l1;
                r_v1 <= 1'b0;
            end
        end else if (!r_v0 || w_pop) begin
            r_v0 <= w_push;
            r_l0 <= w_push && w_last_in;
            if (w_push) r_d0 <= m_rdata;
        end else if (w_push) begin
            r_v1 <= 1'b1;
            r_d1 <= m_rdata;
            r_l1 <= w_last_in;
        end
    end

`ifdef MM2S_PERF_CNT_EN
    logic [31:0] r_perf;

    always_ff @(posedge clk_100_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_perf <= '0;
        end else if (w_start) begin
            r_perf <= '0;
        end else if (r_v0 && !st_ready && (r_perf != '1)) begin
            r_perf <= r_perf + 32'd1;
        end
    end

    assign perf_stall_cnt = r_perf;
`else
    assign perf_stall_cnt = 32'd0;
`endif

    assign status_busy = r_busy;
    assign status_done = r_done;
    assign status_err  = r_err;
    assign m_araddr    = r_araddr;
    assign m_arlen     = r_arlen;
    assign m_arvalid   = r_arvalid;
    assign m_arsize    = 3'(LB);
    assign m_arburst   = 2'b01;
    assign m_arcache   = AR_CACHE;
    assign m_arprot    = AR_PROT;
    assign m_aruser    = AR_USER;
    assign st_data     = r_d0;
    assign st_last     = r_l0;
    assign st_valid    = r_v0;

endmodule

// File: tb/tb_mm2s_burst_reader.sv
// Scoreboard bench for mm2s_burst_reader: AXI slave model, stream and AR monitors.
// Expected perf counter value follows MM2S_PERF_CNT_EN.
`timescale 1ns/1ps
module tb_mm2s_burst_reader;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ctrl_start;
    logic         ctrl_abort;
    logic [31:0]  cfg_base_addr;
    logic [23:0]  cfg_num_beats;
    logic         status_busy;
    logic         status_done;
    logic         status_err;
    logic [31:0]  m_araddr;
    logic [7:0]   m_arlen;
    logic [2:0]   m_arsize;
    logic [1:0]   m_arburst;
    logic [3:0]   m_arcache;
    logic [2:0]   m_arprot;
    logic [4:0]   m_aruser;
    logic         m_arvalid;
    logic         m_arready = 1'b0;
    logic [127:0] m_rdata = '0;
    logic [1:0]   m_rresp = 2'b00;
    logic         m_rlast = 1'b0;
    logic         m_rvalid = 1'b0;
    logic         m_rready;
    logic [127:0] st_data;
    logic         st_last;
    logic         st_valid;
    logic         st_ready;
    logic [31:0]  perf_stall_cnt;

    always #5 clk = ~clk;

    mm2s_burst_reader dut (
        .clk_100_clk    (clk),
        .reset_reset_n  (rst_n),
        .ctrl_start     (ctrl_start),
        .ctrl_abort     (ctrl_abort),
        .cfg_base_addr  (cfg_base_addr),
        .cfg_num_beats  (cfg_num_beats),
        .status_busy    (status_busy),
        .status_done    (status_done),
        .status_err     (status_err),
        .m_araddr       (m_araddr),
        .m_arlen        (m_arlen),
        .m_arsize       (m_arsize),
        .m_arburst      (m_arburst),
        .m_arcache      (m_arcache),
        .m_arprot       (m_arprot),
        .m_aruser       (m_aruser),
        .m_arvalid      (m_arvalid),
        .m_arready      (m_arready),
        .m_rdata        (m_rdata),
        .m_rresp        (m_rresp),
        .m_rlast        (m_rlast),
        .m_rvalid       (m_rvalid),
        .m_rready       (m_rready),
        .st_data        (st_data),
        .st_last        (st_last),
        .st_valid       (st_valid),
        .st_ready       (st_ready),
        .perf_stall_cnt (perf_stall_cnt)
    );

    typedef struct packed {
        logic [127:0] d;
        logic         l;
    } st_t;

    st_t         exp_st[$];
    logic [39:0] exp_ar[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          sl_tot = 0;
    int          sl_left = 0;
    int          err_beat = -1;
    int          stall_seen = 0;
    logic        sl_active = 1'b0;
    logic [31:0] sl_addr = '0;
    logic        tgl_en = 1'b0;
    logic        rdy_lvl = 1'b1;

    function automatic logic [127:0] pat(input logic [31:0] a);
        return {a, ~a, a ^ 32'h5A5A_5A5A, a + 32'd1};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // AXI read slave: arready one cycle after arvalid, back-to-back R beats
    initial begin : slave
        logic        ar_acc;
        logic        r_acc;
        logic [31:0] ar_a;
        logic [7:0]  ar_l;
        forever begin
            @(negedge clk);
            ar_acc = m_arvalid && m_arready;
            ar_a   = m_araddr;
            ar_l   = m_arlen;
            r_acc  = m_rvalid && m_rready;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                sl_active = 1'b0;
            end else begin
                if (r_acc) begin
                    sl_addr = sl_addr + 32'd16;
                    sl_left--;
                    sl_tot++;
                    if (sl_left == 0) sl_active = 1'b0;
                end
                if (ar_acc) begin
                    sl_addr   = ar_a;
                    sl_left   = int'(ar_l) + 1;
                    sl_active = 1'b1;
                end
            end
            m_rvalid  = sl_active;
            m_rdata   = pat(sl_addr);
            m_rlast   = sl_active && (sl_left == 1);
            m_rresp   = (sl_active && sl_tot == err_beat) ? 2'b10 : 2'b00;
            m_arready = rst_n && m_arvalid && !sl_active && !ar_acc;
        end
    end

    initial begin : ready_drv
        st_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            st_ready = tgl_en ? ~st_ready : rdy_lvl;
        end
    end

    // Monitor: pops scoreboards on stream and AR handshakes, checks hold stability
    initial begin : monitor
        logic         prev_stall;
        logic [127:0] prev_d;
        logic         prev_l;
        st_t          e;
        logic [39:0]  a;
        prev_stall = 1'b0;
        prev_d = '0;
        prev_l = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && !ctrl_abort && prev_stall) begin
                chk("st_hold_valid", 128'(st_valid), 128'(1));
                chk("st_hold_data", st_data, prev_d);
                chk("st_hold_last", 128'(st_last), 128'(prev_l));
            end
            prev_stall = st_valid && !st_ready;
            prev_d = st_data;
            prev_l = st_last;
            if (st_valid && !st_ready) stall_seen++;
            if (st_valid && st_ready) begin
                chk("st_expected", 128'(exp_st.size() > 0), 128'(1));
                if (exp_st.size() > 0) begin
                    e = exp_st.pop_front();
                    chk("st_data", st_data, e.d);
                    chk("st_last", 128'(st_last), 128'(e.l));
                end
            end
            if (m_arvalid && m_arready) begin
                chk("ar_expected", 128'(exp_ar.size() > 0), 128'(1));
                if (exp_ar.size() > 0) begin
                    a = exp_ar.pop_front();
                    chk("ar_addr", 128'(m_araddr), 128'(a[39:8]));
                    chk("ar_len", 128'(m_arlen), 128'(a[7:0]));
                end
            end
        end
    end

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start();
        @(posedge clk);
        #1 ctrl_start = 1'b1;
        repeat (3) @(posedge clk);
        #1 ctrl_start = 1'b0;
    endtask

    task automatic run(input logic [31:0] base, input int n,
                       input int err_at, input bit push);
        st_t e;
        if (push) begin
            for (int i = 0; i < n; i++) begin
                e.d = pat(base + 32'(16 * i));
                e.l = (i == n - 1);
                exp_st.push_back(e);
            end
        end
        cfg_base_addr = base;
        cfg_num_beats = 24'(n);
        err_beat = (err_at < 0) ? -1 : sl_tot + err_at;
        pulse_start();
    endtask

    task automatic wait_idle(input int max);
        int k;
        k = 0;
        while (status_busy && k < max) begin
            @(negedge clk);
            k++;
        end
        chk("idle_reached", 128'(status_busy), 128'(0));
    endtask

    task automatic end_chk(input string nm, input logic dn, input logic er);
        wait_idle(800);
        chk({nm, "_done"}, 128'(status_done), 128'(dn));
        chk({nm, "_err"}, 128'(status_err), 128'(er));
        chk({nm, "_st_q"}, 128'(exp_st.size()), 128'(0));
        chk({nm, "_ar_q"}, 128'(exp_ar.size()), 128'(0));
    endtask

    initial begin : main
        int t0;
        int s0;
        int k;
        ctrl_start = 1'b0;
        ctrl_abort = 1'b0;
        cfg_base_addr = '0;
        cfg_num_beats = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 128'(status_busy), 128'(0));
        chk("rst_done", 128'(status_done), 128'(0));
        chk("rst_arvalid", 128'(m_arvalid), 128'(0));
        chk("rst_rready", 128'(m_rready), 128'(0));
        chk("rst_st_valid", 128'(st_valid), 128'(0));
        chk("rst_arsize", 128'(m_arsize), 128'(4));
        chk("rst_arburst", 128'(m_arburst), 128'(1));
        chk("rst_arcache", 128'(m_arcache), 128'(3));
        chk("rst_prot_user", 128'({m_arprot, m_aruser}), 128'(0));
        chk("rst_perf", 128'(perf_stall_cnt), 128'(0));
        rst_n = 1'b1;

        exp_ar.push_back({32'h1000_0000, 8'd15});
        exp_ar.push_back({32'h1000_0100, 8'd15});
        exp_ar.push_back({32'h1000_0200, 8'd7});
        run(32'h1000_0000, 40, -1, 1);
        end_chk("t1_40beats", 1'b1, 1'b0);

        exp_ar.push_back({32'h0000_0FC0, 8'd3});
        exp_ar.push_back({32'h0000_1000, 8'd15});
        run(32'h0000_0FC0, 20, -1, 1);
        end_chk("t2_4kb", 1'b1, 1'b0);

        s0 = stall_seen;
        tgl_en = 1'b1;
        exp_ar.push_back({32'h2000_0000, 8'd7});
        run(32'h2000_0000, 8, -1, 1);
        end_chk("t3_toggle", 1'b1, 1'b0);
        tgl_en = 1'b0;
`ifdef MM2S_PERF_CNT_EN
        chk("t3_perf", 128'(perf_stall_cnt), 128'(stall_seen - s0));
`else
        chk("t3_perf", 128'(perf_stall_cnt), 128'(0));
`endif

        exp_ar.push_back({32'h3000_0000, 8'd15});
        run(32'h3000_0000, 16, 4, 1);
        end_chk("t4_slverr", 1'b1, 1'b1);

        rdy_lvl = 1'b0;
        t0 = sl_tot;
        exp_ar.push_back({32'h4000_0000, 8'd15});
        run(32'h4000_0000, 64, -1, 0);
        k = 0;
        while (!(m_rvalid && !m_rready && (sl_tot - t0 == 2)) && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("t5_beat3_stalled", 128'(sl_tot - t0), 128'(2));
        @(posedge clk);
        #1 ctrl_abort = 1'b1;
        end_chk("t5_abort", 1'b0, 1'b0);
        ctrl_abort = 1'b0;
        rdy_lvl = 1'b1;
        repeat (5) @(negedge clk);
        chk("t5_drained", 128'(sl_tot - t0), 128'(16));
        chk("t5_no_ar", 128'(m_arvalid), 128'(0));
        chk("t5_st_idle", 128'(st_valid), 128'(0));

        cfg_num_beats = '0;
        cfg_base_addr = 32'h0000_0100;
        @(posedge clk);
        #1 ctrl_start = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("t6_busy_e1", 128'(status_busy), 128'(1));
        chk("t6_done_e1", 128'(status_done), 128'(0));
        @(posedge clk);
        #1;
        chk("t6_busy_e2", 128'(status_busy), 128'(0));
        chk("t6_done_e2", 128'(status_done), 128'(1));
        ctrl_start = 1'b0;
        repeat (3) @(posedge clk);

        t0 = sl_tot;
        exp_ar.push_back({32'h5000_0000, 8'd15});
        exp_ar.push_back({32'h5000_0100, 8'd15});
        exp_ar.push_back({32'h5000_0200, 8'd7});
        run(32'h5000_0000, 40, -1, 1);
        k = 0;
        while ((sl_tot - t0 < 5) && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("t7_flowing", 128'(sl_tot - t0 >= 5), 128'(1));
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("t7_busy", 128'(status_busy), 128'(0));
        chk("t7_arvalid", 128'(m_arvalid), 128'(0));
        chk("t7_rready", 128'(m_rready), 128'(0));
        chk("t7_st", 128'({st_valid, st_last}), 128'(0));
        chk("t7_st_data", st_data, 128'(0));
        chk("t7_ar_bus", 128'({m_araddr, m_arlen}), 128'(0));
        exp_st.delete();
        exp_ar.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        exp_ar.push_back({32'h6000_0000, 8'd7});
        run(32'h6000_0000, 8, -1, 1);
        end_chk("t8_recover", 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
